// File: rtl/pattern_scan_ctrl.sv
// Pattern scan controller: streams a captured 16-bit word MSB-first through a
// detector bank once per pattern 0..15 and collects hits. `PATTERN_SCAN_COUNT_EN adds hit_cnt.
module pattern_scan_ctrl (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] data_in,
    input  logic        det_hit,
    output logic        det_seq,
    output logic [3:0]  det_sel,
    output logic        det_clr_n,
    output logic        busy,
    output logic        done,
    output logic [15:0] hit_mask
`ifdef PATTERN_SCAN_COUNT_EN
    ,
    output logic [8:0]  hit_cnt
`endif
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        SHIFT = 3'd2,
        DRAIN = 3'd3,
        NEXT  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] word_q, word_d;
    logic [3:0]  bitcnt_q, bitcnt_d;
    logic [3:0]  sel_q, sel_d;
    logic [15:0] mask_q, mask_d;
    logic        seq_q, seq_d;
    logic        clr_n_q, clr_n_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        sample;
    logic [3:0]  seq_idx;
`ifdef PATTERN_SCAN_COUNT_EN
    logic [8:0]  cnt_q, cnt_d;
`endif

    always_comb begin
        state_d  = state_q;
        word_d   = word_q;
        bitcnt_d = bitcnt_q;
        sel_d    = sel_q;
        mask_d   = mask_q;
        sample   = 1'b0;
`ifdef PATTERN_SCAN_COUNT_EN
        cnt_d    = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    word_d  = data_in;
                    mask_d  = 16'h0000;
                    sel_d   = 4'd0;
                    state_d = CLEAR;
`ifdef PATTERN_SCAN_COUNT_EN
                    cnt_d   = 9'd0;
`endif
                end
            end
            CLEAR: begin
                bitcnt_d = 4'd0;
                state_d  = SHIFT;
            end
            SHIFT: begin
                // The first shifted bit cannot complete a 4-bit window yet.
                sample = (bitcnt_q != 4'd0);
                if (bitcnt_q == 4'd15) begin
                    state_d = DRAIN;
                end else begin
                    bitcnt_d = bitcnt_q + 4'd1;
                end
            end
            DRAIN: begin
                sample  = 1'b1;
                state_d = NEXT;
            end
            NEXT: begin
                if (sel_q == 4'd15) begin
                    state_d = IDLE;
                end else begin
                    sel_d   = sel_q + 4'd1;
                    state_d = CLEAR;
                end
            end
            default: state_d = IDLE;
        endcase

        if (sample && det_hit) begin
            mask_d[sel_q] = 1'b1;
`ifdef PATTERN_SCAN_COUNT_EN
            cnt_d = cnt_q + 9'd1;
`endif
        end

        // Outputs are registered from the next state so they line up with it.
        seq_idx = 4'd15 - bitcnt_d;
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == NEXT) && (sel_d == 4'd15);
        clr_n_d = (state_d != CLEAR);
        seq_d   = (state_d == SHIFT) && word_d[seq_idx];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            word_q   <= 16'h0000;
            bitcnt_q <= 4'd0;
            sel_q    <= 4'd0;
            mask_q   <= 16'h0000;
            seq_q    <= 1'b0;
            clr_n_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef PATTERN_SCAN_COUNT_EN
            cnt_q    <= 9'd0;
`endif
        end else begin
            state_q  <= state_d;
            word_q   <= word_d;
            bitcnt_q <= bitcnt_d;
            sel_q    <= sel_d;
            mask_q   <= mask_d;
            seq_q    <= seq_d;
            clr_n_q  <= clr_n_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef PATTERN_SCAN_COUNT_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign det_seq   = seq_q;
    assign det_sel   = sel_q;
    assign det_clr_n = clr_n_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign hit_mask  = mask_q;
`ifdef PATTERN_SCAN_COUNT_EN
    assign hit_cnt   = cnt_q;
`endif

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Bench for pattern_scan_ctrl: behavioural 4-bit window detector bank, directed
// scans with hand-computed hit masks, and a protocol monitor on the detector interface.
module tb_pattern_scan_ctrl;

    logic        clock;
    logic        reset;
    logic        start;
    logic [15:0] data_in;
    logic        det_hit;
    logic        det_seq;
    logic [3:0]  det_sel;
    logic        det_clr_n;
    logic        busy;
    logic        done;
    logic [15:0] hit_mask;
`ifdef PATTERN_SCAN_COUNT_EN
    logic [8:0]  hit_cnt;
`endif

    int n_total = 0;
    int n_bad   = 0;

    pattern_scan_ctrl dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .data_in   (data_in),
        .det_hit   (det_hit),
        .det_seq   (det_seq),
        .det_sel   (det_sel),
        .det_clr_n (det_clr_n),
        .busy      (busy),
        .done      (done),
        .hit_mask  (hit_mask)
`ifdef PATTERN_SCAN_COUNT_EN
        ,
        .hit_cnt   (hit_cnt)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Detector bank: Moore match once 4 bits have entered since the last clear.
    logic [3:0] win;
    int         vcnt;
    always @(posedge clock) begin
        if (!det_clr_n) begin
            win  <= 4'd0;
            vcnt <= 0;
        end else begin
            win <= {win[2:0], det_seq};
            if (vcnt < 4) vcnt <= vcnt + 1;
        end
    end
    assign det_hit = (vcnt == 4) && (win == det_sel);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    // Protocol monitor, sampled on the falling edge.
    bit          mon_en    = 1'b0;
    bit          mon_shift = 1'b0;
    logic [15:0] mon_word  = 16'h0;
    int          mon_sel_exp = 0;
    int          mon_bit   = 0;
    int          clr_cnt   = 0;
    always @(negedge clock) begin
        if (mon_en && reset) begin
            if (!det_clr_n) begin
                check("clr_sel", 32'(det_sel), 32'(mon_sel_exp));
                mon_sel_exp++;
                clr_cnt++;
                mon_bit   = 0;
                mon_shift = 1'b1;
            end else if (mon_shift) begin
                check("seq_bit", 32'(det_seq), 32'(mon_word[15-mon_bit]));
                mon_bit++;
                if (mon_bit == 16) mon_shift = 1'b0;
            end else begin
                check("seq_idle", 32'(det_seq), 32'd0);
            end
        end
    end

    task automatic do_scan(input logic [15:0] w, input logic [15:0] exp_mask, input bit extra);
        int n;
        int done_at;
        int done_cnt;
        @(posedge clock); #1;
        data_in     = w;
        start       = 1'b1;
        mon_word    = w;
        mon_sel_exp = 0;
        clr_cnt     = 0;
        mon_shift   = 1'b0;
        mon_en      = 1'b1;
        @(posedge clock); #1;
        start    = 1'b0;
        data_in  = 16'(~w);
        done_at  = 0;
        done_cnt = 0;
        for (n = 1; n <= 310; n++) begin
            if (done) begin
                done_cnt++;
                done_at = n;
            end
            if (n == 1)   check("busy_first", 32'(busy), 32'd1);
            if (n == 304) check("busy_at_done", 32'(busy), 32'd1);
            if (n == 305) check("busy_after_done", 32'(busy), 32'd0);
            if (n == 306) check("start_on_done_ignored", 32'(busy), 32'd0);
            start = extra && (n == 5 || n == 150 || n == 304);
            @(posedge clock); #1;
        end
        start = 1'b0;
        check("done_count", 32'(done_cnt), 32'd1);
        check("done_cycle", 32'(done_at), 32'd304);
        check("hit_mask", 32'(hit_mask), 32'(exp_mask));
        check("sel_hold", 32'(det_sel), 32'd15);
        check("clr_pulses", 32'(clr_cnt), 32'd16);
`ifdef PATTERN_SCAN_COUNT_EN
        check("hit_cnt", 32'(hit_cnt), 32'd13);
`endif
        mon_en = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        check("mask_hold", 32'(hit_mask), 32'(exp_mask));
        check("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        int n;
        int seen_done;
        reset   = 1'b0;
        start   = 1'b0;
        data_in = 16'h0000;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_mask", 32'(hit_mask), 32'd0);
        check("rst_sel", 32'(det_sel), 32'd0);
        check("rst_seq", 32'(det_seq), 32'd0);
        check("rst_clr_n", 32'(det_clr_n), 32'd0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
        check("clr_n_after_rst", 32'(det_clr_n), 32'd1);

        do_scan(16'h0000, 16'h0001, 1'b0);
        do_scan(16'hFFFF, 16'h8000, 1'b0);
        do_scan(16'h1234, 16'h275E, 1'b1);
        do_scan(16'h0000, 16'h0001, 1'b1);

        // Asynchronous reset in the middle of a scan.
        @(posedge clock); #1;
        data_in = 16'h1234;
        start   = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (99) @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_mask", 32'(hit_mask), 32'd0);
        check("abort_sel", 32'(det_sel), 32'd0);
        check("abort_clr_n", 32'(det_clr_n), 32'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        seen_done = 0;
        for (n = 0; n < 320; n++) begin
            @(posedge clock); #1;
            if (done) seen_done++;
        end
        check("abort_no_done", 32'(seen_done), 32'd0);
        check("abort_idle_busy", 32'(busy), 32'd0);
        check("abort_idle_mask", 32'(hit_mask), 32'd0);

        do_scan(16'hFFFF, 16'h8000, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
